// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc definitions: opcodes, immediate modifiers, instruction field
// slicing and the issue-entry layout used by the operand/issue stage.
package simplerisc_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_CMP = 5'd5;
  localparam logic [4:0] OP_AND = 5'd6;
  localparam logic [4:0] OP_OR  = 5'd7;
  localparam logic [4:0] OP_NOT = 5'd8;
  localparam logic [4:0] OP_MOV = 5'd9;
  localparam logic [4:0] OP_LSL = 5'd10;
  localparam logic [4:0] OP_LSR = 5'd11;
  localparam logic [4:0] OP_ASR = 5'd12;
  localparam logic [4:0] OP_NOP = 5'd13;
  localparam logic [4:0] OP_LD  = 5'd14;
  localparam logic [4:0] OP_ST  = 5'd15;
  localparam logic [4:0] OP_BEQ = 5'd16;
  localparam logic [4:0] OP_BGT = 5'd17;
  localparam logic [4:0] OP_B   = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET = 5'd20;

  localparam logic [1:0] MOD_DEF = 2'b00;
  localparam logic [1:0] MOD_U   = 2'b01;
  localparam logic [1:0] MOD_H   = 2'b10;

  localparam logic [4:0] ALU_ADD = 5'd0;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] immx;
    logic            is_imm;
    logic [4:0]      alu;
    logic [XLEN-1:0] store_data;
    logic [3:0]      rd;
    logic            writes;
  } issue_entry_t;

  function automatic logic [4:0] f_opc(input logic [31:0] inst);
    return inst[31:27];
  endfunction

  function automatic logic f_ibit(input logic [31:0] inst);
    return inst[26];
  endfunction

  function automatic logic [3:0] f_rd(input logic [31:0] inst);
    return inst[25:22];
  endfunction

  function automatic logic [3:0] f_rs1(input logic [31:0] inst);
    return inst[21:18];
  endfunction

  function automatic logic [3:0] f_rs2(input logic [31:0] inst);
    return inst[17:14];
  endfunction

  // mod 11 is treated like the default signed form.
  function automatic logic [XLEN-1:0] f_immx(input logic [31:0] inst);
    logic [15:0] imm16;
    logic [XLEN-1:0] res;
    imm16 = inst[15:0];
    case (inst[17:16])
      MOD_U:   res = {16'h0000, imm16};
      MOD_H:   res = {imm16, 16'h0000};
      default: res = {{16{imm16[15]}}, imm16};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/simplerisc_regfile.sv
// 16x32 register file with three asynchronous read ports and one write port;
// reads of the register being written this cycle see the incoming data.
module simplerisc_regfile
  import simplerisc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [3:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [3:0]      raddr0_i,
  input  logic [3:0]      raddr1_i,
  input  logic [3:0]      raddr2_i,
  output logic [XLEN-1:0] rdata0_o,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] mem_q [NREGS];

  // Storage update: clear everything on reset, otherwise take the writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = (we_i && (waddr_i == raddr0_i)) ? wdata_i : mem_q[raddr0_i];
  assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];

endmodule

// File: rtl/operand_issue_unit.sv
// SimpleRisc decode/operand-fetch stage: reads operands, builds the immediate,
// stalls on scoreboard hazards and issues into a one-entry register toward EX.
module operand_issue_unit
  import simplerisc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instValid,
  input  logic [31:0]     inst,
  output logic            instReady,
  input  logic            flush,
  input  logic            wbEn,
  input  logic [3:0]      wbRd,
  input  logic [XLEN-1:0] wbData,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] immx,
  output logic            isImmediate,
  output logic [4:0]      aluSignals,
  output logic [XLEN-1:0] storeData,
  output logic [3:0]      issueRd,
  output logic            issueWrites,
  output logic            issueValid,
  input  logic            issueReady
);

  logic [4:0]      opc_s;
  logic            ibit_s;
  logic [3:0]      rd_s, rs1_s, rs2_s;
  logic [XLEN-1:0] rs1_val_s, rs2_val_s, rd_val_s;
  logic            is_alu_s, is_ld_s, is_st_s, issuable_s, writes_s;
  logic            use_rs1_s, use_rs2_s;
  logic            busy_rs1_s, busy_rs2_s, busy_rd_s, hazard_s, accept_s;
  logic [NREGS-1:0] pending_q, pending_d, set_mask_s, clr_mask_s;
  issue_entry_t    entry_q, entry_d, new_entry_s;
  logic            valid_q, valid_d;

  assign opc_s  = f_opc(inst);
  assign ibit_s = f_ibit(inst);
  assign rd_s   = f_rd(inst);
  assign rs1_s  = f_rs1(inst);
  assign rs2_s  = f_rs2(inst);

  simplerisc_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wbEn),
    .waddr_i  (wbRd),
    .wdata_i  (wbData),
    .raddr0_i (rs1_s),
    .raddr1_i (rs2_s),
    .raddr2_i (rd_s),
    .rdata0_o (rs1_val_s),
    .rdata1_o (rs2_val_s),
    .rdata2_o (rd_val_s)
  );

  assign is_alu_s   = (opc_s <= OP_ASR);
  assign is_ld_s    = (opc_s == OP_LD);
  assign is_st_s    = (opc_s == OP_ST);
  assign issuable_s = is_alu_s | is_ld_s | is_st_s;
  assign writes_s   = (is_alu_s & (opc_s != OP_CMP)) | is_ld_s;
  assign use_rs1_s  = (is_alu_s & (opc_s != OP_MOV) & (opc_s != OP_NOT)) | is_ld_s | is_st_s;
  assign use_rs2_s  = issuable_s & ~ibit_s;

  // A pending register being written back this cycle no longer blocks.
  assign busy_rs1_s = pending_q[rs1_s] & ~(wbEn & (wbRd == rs1_s));
  assign busy_rs2_s = pending_q[rs2_s] & ~(wbEn & (wbRd == rs2_s));
  assign busy_rd_s  = pending_q[rd_s]  & ~(wbEn & (wbRd == rd_s));

  assign hazard_s = issuable_s & ((use_rs1_s & busy_rs1_s) | (use_rs2_s & busy_rs2_s) |
                                  ((is_st_s | writes_s) & busy_rd_s));
  assign accept_s  = instValid & ~flush & ~hazard_s & (~valid_q | issueReady);
  assign instReady = accept_s;

  // Operand set for the instruction currently offered by fetch.
  always_comb begin
    new_entry_s            = '0;
    new_entry_s.op1        = rs1_val_s;
    new_entry_s.op2        = rs2_val_s;
    new_entry_s.immx       = f_immx(inst);
    new_entry_s.is_imm     = is_alu_s ? ibit_s : 1'b1;
    new_entry_s.alu        = is_alu_s ? opc_s : ALU_ADD;
    new_entry_s.store_data = is_st_s ? rd_val_s : '0;
    new_entry_s.rd         = rd_s;
    new_entry_s.writes     = writes_s;
  end

  // Next state of the output entry; flush wins over any load or drain.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s && issuable_s) begin
      entry_d = new_entry_s;
      valid_d = 1'b1;
    end else if (issueReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Scoreboard next state; the set mask is applied last so set beats clear.
  always_comb begin
    set_mask_s = (accept_s && issuable_s && writes_s) ? (NREGS'(1) << rd_s) : '0;
    clr_mask_s = (wbEn ? (NREGS'(1) << wbRd) : '0) |
                 ((flush && valid_q && entry_q.writes) ? (NREGS'(1) << entry_q.rd) : '0);
    pending_d  = (pending_q & ~clr_mask_s) | set_mask_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q   <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      entry_q   <= entry_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
    end
  end

  assign op1         = entry_q.op1;
  assign op2         = entry_q.op2;
  assign immx        = entry_q.immx;
  assign isImmediate = entry_q.is_imm;
  assign aluSignals  = entry_q.alu;
  assign storeData   = entry_q.store_data;
  assign issueRd     = entry_q.rd;
  assign issueWrites = entry_q.writes;
  assign issueValid  = valid_q;

endmodule

// File: tb/tb_operand_issue_unit.sv
// Directed, table-driven bench for operand_issue_unit with hand-computed
// expectations plus hand-written reset-mid-stall sequence.
module tb_operand_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instValid;
  logic [31:0] inst;
  logic        instReady;
  logic        flush;
  logic        wbEn;
  logic [3:0]  wbRd;
  logic [31:0] wbData;
  logic [31:0] op1, op2, immx, storeData;
  logic        isImmediate, issueWrites, issueValid, issueReady;
  logic [4:0]  aluSignals;
  logic [3:0]  issueRd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operand_issue_unit dut (
    .clk(clk), .rst_n(rst_n), .instValid(instValid), .inst(inst), .instReady(instReady),
    .flush(flush), .wbEn(wbEn), .wbRd(wbRd), .wbData(wbData),
    .op1(op1), .op2(op2), .immx(immx), .isImmediate(isImmediate), .aluSignals(aluSignals),
    .storeData(storeData), .issueRd(issueRd), .issueWrites(issueWrites),
    .issueValid(issueValid), .issueReady(issueReady)
  );

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic        we;
    logic [3:0]  wrd;
    logic [31:0] wdat;
    logic        ir;
    logic        fl;
    logic        e_ready;
    logic        e_valid;
    logic        chk;
    logic [31:0] e_op1, e_op2, e_immx;
    logic        e_imm;
    logic [4:0]  e_alu;
    logic [31:0] e_store;
    logic [3:0]  e_rd;
    logic        e_wr;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [31:0] enc_r(input logic [4:0] opc, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    return {opc, 1'b0, rd, rs1, rs2, 14'h0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] opc, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [1:0] md,
                                        input logic [15:0] imm);
    return {opc, 1'b1, rd, rs1, md, imm};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] ins, input logic we,
                              input logic [3:0] wrd, input logic [31:0] wdat, input logic ir,
                              input logic fl, input logic e_ready, input logic e_valid,
                              input logic chk, input logic [31:0] e_op1, input logic [31:0] e_op2,
                              input logic [31:0] e_immx, input logic e_imm, input logic [4:0] e_alu,
                              input logic [31:0] e_store, input logic [3:0] e_rd, input logic e_wr);
    vec_t v;
    v.iv = iv; v.ins = ins; v.we = we; v.wrd = wrd; v.wdat = wdat; v.ir = ir; v.fl = fl;
    v.e_ready = e_ready; v.e_valid = e_valid; v.chk = chk;
    v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_immx = e_immx; v.e_imm = e_imm;
    v.e_alu = e_alu; v.e_store = e_store; v.e_rd = e_rd; v.e_wr = e_wr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic we, input logic [3:0] wrd,
                       input logic [31:0] wdat, input logic ir, input logic fl);
    instValid = iv; inst = ins; wbEn = we; wbRd = wrd; wbData = wdat; issueReady = ir; flush = fl;
  endtask

  initial begin
    // Row fields: iv, inst, wbEn, wbRd, wbData, issueReady, flush,
    //             exp instReady, exp issueValid, check entry?, op1, op2, immx, isImm, alu, store, rd, writes
    vecs[0]  = mk(0, 32'h0, 1, 4'd1, 32'd5, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 32'h0, 1, 4'd2, 32'd7, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, enc_r(5'd0, 4'd3, 4'd1, 4'd2), 0, 4'd0, 32'd0, 1, 0,
                  1, 1, 1, 32'd5, 32'd7, 32'hFFFF8000, 0, 5'd0, 32'd0, 4'd3, 1);
    vecs[3]  = mk(1, enc_r(5'd1, 4'd5, 4'd3, 4'd1), 0, 4'd0, 32'd0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, enc_r(5'd1, 4'd5, 4'd3, 4'd1), 0, 4'd0, 32'd0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, enc_r(5'd1, 4'd5, 4'd3, 4'd1), 1, 4'd3, 32'd12, 1, 0,
                  1, 1, 1, 32'd12, 32'd5, 32'h00004000, 0, 5'd1, 32'd0, 4'd5, 1);
    vecs[6]  = mk(1, enc_i(5'd9, 4'd4, 4'd0, 2'b00, 16'hFFFF), 0, 4'd0, 32'd0, 1, 0,
                  1, 1, 1, 32'd0, 32'd12, 32'hFFFFFFFF, 1, 5'd9, 32'd0, 4'd4, 1);
    vecs[7]  = mk(1, enc_i(5'd9, 4'd4, 4'd0, 2'b01, 16'hFFFF), 1, 4'd4, 32'h44, 1, 0,
                  1, 1, 1, 32'd0, 32'd0, 32'h0000FFFF, 1, 5'd9, 32'd0, 4'd4, 1);
    vecs[8]  = mk(1, enc_i(5'd9, 4'd4, 4'd0, 2'b10, 16'hFFFF), 1, 4'd4, 32'h44, 1, 0,
                  1, 1, 1, 32'd0, 32'd0, 32'hFFFF0000, 1, 5'd9, 32'd0, 4'd4, 1);
    for (int i = 9; i < 12; i++) begin
      vecs[i] = mk(1, enc_i(5'd9, 4'd8, 4'd0, 2'b00, 16'h0001), 0, 4'd0, 32'd0, 0, 0,
                   0, 1, 1, 32'd0, 32'd0, 32'hFFFF0000, 1, 5'd9, 32'd0, 4'd4, 1);
    end
    vecs[12] = mk(1, enc_i(5'd9, 4'd8, 4'd0, 2'b00, 16'h0001), 0, 4'd0, 32'd0, 1, 0,
                  1, 1, 1, 32'd0, 32'd0, 32'h00000001, 1, 5'd9, 32'd0, 4'd8, 1);
    vecs[13] = mk(0, 32'h0, 0, 4'd0, 32'd0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, enc_r(5'd0, 4'd6, 4'd1, 4'd2), 0, 4'd0, 32'd0, 0, 0,
                  1, 1, 1, 32'd5, 32'd7, 32'hFFFF8000, 0, 5'd0, 32'd0, 4'd6, 1);
    vecs[15] = mk(1, enc_r(5'd0, 4'd7, 4'd6, 4'd6), 0, 4'd0, 32'd0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, enc_r(5'd0, 4'd7, 4'd6, 4'd6), 0, 4'd0, 32'd0, 0, 0,
                  1, 1, 1, 32'd0, 32'd0, 32'h00008000, 0, 5'd0, 32'd0, 4'd7, 1);
    vecs[17] = mk(0, 32'h0, 0, 4'd0, 32'd0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, enc_i(5'd15, 4'd2, 4'd1, 2'b00, 16'h0004), 0, 4'd0, 32'd0, 1, 0,
                  1, 1, 1, 32'd5, 32'd0, 32'h00000004, 1, 5'd0, 32'd7, 4'd2, 0);
    vecs[19] = mk(1, {5'd13, 27'h0}, 0, 4'd0, 32'd0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(0, 32'h0, 0, 4'd0, 32'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'h0, issueValid}, 32'd0);
    chk("reset_op1", op1, 32'd0);
    chk("reset_alu", {27'h0, aluSignals}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].ins, vecs[i].we, vecs[i].wrd, vecs[i].wdat, vecs[i].ir, vecs[i].fl);
      #1;
      chk($sformatf("v%0d_instReady", i), {31'h0, instReady}, {31'h0, vecs[i].e_ready});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_issueValid", i), {31'h0, issueValid}, {31'h0, vecs[i].e_valid});
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_op1", i), op1, vecs[i].e_op1);
        chk($sformatf("v%0d_op2", i), op2, vecs[i].e_op2);
        chk($sformatf("v%0d_immx", i), immx, vecs[i].e_immx);
        chk($sformatf("v%0d_isImm", i), {31'h0, isImmediate}, {31'h0, vecs[i].e_imm});
        chk($sformatf("v%0d_alu", i), {27'h0, aluSignals}, {27'h0, vecs[i].e_alu});
        chk($sformatf("v%0d_store", i), storeData, vecs[i].e_store);
        chk($sformatf("v%0d_rd", i), {28'h0, issueRd}, {28'h0, vecs[i].e_rd});
        chk($sformatf("v%0d_writes", i), {31'h0, issueWrites}, {31'h0, vecs[i].e_wr});
      end
    end

    // Reset in the middle of a stall: r5 is still pending, entry holds the st.
    @(negedge clk);
    drive(1, enc_r(5'd0, 4'd9, 4'd5, 4'd1), 0, 4'd0, 32'd0, 0, 0);
    #1;
    chk("stall_instReady", {31'h0, instReady}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'h0, issueValid}, 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_immx", immx, 32'd0);
    chk("rst_store", storeData, 32'd0);
    chk("rst_rd", {28'h0, issueRd}, 32'd0);
    chk("rst_isImm", {31'h0, isImmediate}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, enc_r(5'd0, 4'd9, 4'd5, 4'd1), 0, 4'd0, 32'd0, 1, 0);
    #1;
    chk("post_rst_instReady", {31'h0, instReady}, 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'h0, issueValid}, 32'd1);
    chk("post_rst_op1", op1, 32'd0);
    chk("post_rst_op2", op2, 32'd0);
    chk("post_rst_rd", {28'h0, issueRd}, 32'd9);
    @(negedge clk);
    drive(0, 32'h0, 0, 4'd0, 32'd0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
